// File: rtl/graphics_pkg.sv
// Shared constants and encodings for the sprite animation sequencer and its axis bouncers.
package graphics_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 272;
    localparam int SPRITE_H = 176;

    typedef enum logic [1:0] {
        CMD_RUN       = 2'd0,
        CMD_PAUSE     = 2'd1,
        CMD_STEP      = 2'd2,
        CMD_SET_SPEED = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_PAUSED    = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_STEP_PEND = 2'd2,
        ST_UPDATE    = 2'd3
    } state_e;

endpackage

// File: rtl/axis_bouncer.sv
// One motion axis: position/direction registers that bounce between 0 and LIMIT.
module axis_bouncer
    import graphics_pkg::*;
#(
    parameter int LIMIT    = 368,
    parameter int POS_BITS = 10,
    parameter int INIT     = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_en,
    input  logic [3:0]          speed,
    output logic [POS_BITS-1:0] pos,
    output logic                dir
);

    localparam logic signed [POS_BITS:0] LIMIT_S = LIMIT[POS_BITS:0];
    localparam logic signed [POS_BITS:0] ZERO_S  = '0;

    logic [POS_BITS-1:0]        pos_r;
    logic                       dir_r;
    logic signed [POS_BITS:0]   nxt_s;
    logic signed [POS_BITS:0]   speed_s;
    logic [POS_BITS-1:0]        pos_nxt_s;
    logic                       dir_nxt_s;

    assign speed_s = $signed({{(POS_BITS-3){1'b0}}, speed});

    // Candidate move plus clamp at either edge; zero speed leaves the axis untouched.
    always_comb begin
        pos_nxt_s = pos_r;
        dir_nxt_s = dir_r;
        nxt_s     = dir_r ? ($signed({1'b0, pos_r}) + speed_s)
                          : ($signed({1'b0, pos_r}) - speed_s);
        if (speed == 4'd0) begin
            pos_nxt_s = pos_r;
            dir_nxt_s = dir_r;
        end else if (nxt_s >= LIMIT_S) begin
            pos_nxt_s = LIMIT_S[POS_BITS-1:0];
            dir_nxt_s = 1'b0;
        end else if (nxt_s <= ZERO_S) begin
            pos_nxt_s = '0;
            dir_nxt_s = 1'b1;
        end else begin
            pos_nxt_s = nxt_s[POS_BITS-1:0];
            dir_nxt_s = dir_r;
        end
    end

    // Position and direction registers, advanced only on an update cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_r <= INIT[POS_BITS-1:0];
            dir_r <= 1'b1;
        end else if (step_en) begin
            pos_r <= pos_nxt_s;
            dir_r <= dir_nxt_s;
        end else begin
            pos_r <= pos_r;
            dir_r <= dir_r;
        end
    end

    assign pos = pos_r;
    assign dir = dir_r;

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Per-frame scheduler: command FSM, speed register, cel/rainbow counters and two bouncing axes.
module sprite_anim_sequencer
    import graphics_pkg::*;
#(
    parameter int INIT_LEFT      = 128,
    parameter int INIT_TOP       = 128,
    parameter int FRAMES_PER_CEL = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [9:0] sprite_left,
    output logic [9:0] sprite_top,
    output logic       cel_sel,
    output logic [2:0] rainbow_phase,
    output logic       update_done
);

    localparam int CEL_BITS = $clog2(FRAMES_PER_CEL);
    localparam int MAX_X    = SCREEN_W - SPRITE_W;
    localparam int MAX_Y    = SCREEN_H - SPRITE_H;
    localparam logic [CEL_BITS-1:0] CEL_LAST = CEL_BITS'(FRAMES_PER_CEL - 1);

    state_e              state_r, state_nxt_s;
    state_e              ret_r, ret_nxt_s;
    cmd_op_e             op_s;
    logic                cmd_ready_r;
    logic                cmd_fire_s;
    logic                upd_s;
    logic [3:0]          speed_r;
    logic [CEL_BITS-1:0] cel_cnt_r;
    logic                cel_r;
    logic [2:0]          phase_r;
    logic                done_r;
    logic                dx_s, dy_s;

    assign op_s       = cmd_op_e'(cmd_op);
    assign cmd_fire_s = cmd_valid & cmd_ready_r;
    assign upd_s      = (state_r == ST_UPDATE);

    // Next state and return state; a frame update always wins, a same-cycle command only steers ret.
    always_comb begin
        state_nxt_s = state_r;
        ret_nxt_s   = ret_r;
        case (state_r)
            ST_PAUSED: begin
                if (cmd_fire_s && (op_s == CMD_RUN)) begin
                    state_nxt_s = ST_RUNNING;
                end else if (cmd_fire_s && (op_s == CMD_STEP)) begin
                    state_nxt_s = ST_STEP_PEND;
                end else begin
                    state_nxt_s = ST_PAUSED;
                end
            end
            ST_RUNNING: begin
                if (frame_start) begin
                    state_nxt_s = ST_UPDATE;
                    ret_nxt_s   = (cmd_fire_s && (op_s == CMD_PAUSE)) ? ST_PAUSED : ST_RUNNING;
                end else if (cmd_fire_s && (op_s == CMD_PAUSE)) begin
                    state_nxt_s = ST_PAUSED;
                end else begin
                    state_nxt_s = ST_RUNNING;
                end
            end
            ST_STEP_PEND: begin
                if (frame_start) begin
                    state_nxt_s = ST_UPDATE;
                    ret_nxt_s   = (cmd_fire_s && (op_s == CMD_RUN)) ? ST_RUNNING : ST_PAUSED;
                end else if (cmd_fire_s && (op_s == CMD_PAUSE)) begin
                    state_nxt_s = ST_PAUSED;
                end else if (cmd_fire_s && (op_s == CMD_RUN)) begin
                    state_nxt_s = ST_RUNNING;
                end else begin
                    state_nxt_s = ST_STEP_PEND;
                end
            end
            ST_UPDATE: begin
                state_nxt_s = ret_r;
            end
            default: begin
                state_nxt_s = ST_PAUSED;
                ret_nxt_s   = ST_PAUSED;
            end
        endcase
    end

    // FSM registers; cmd_ready is registered from the next state so it drops exactly in UPDATE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_PAUSED;
            ret_r       <= ST_PAUSED;
            cmd_ready_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            ret_r       <= ret_nxt_s;
            cmd_ready_r <= (state_nxt_s != ST_UPDATE);
        end
    end

    // Speed register; loading one edge early means a SET_SPEED paired with frame_start is seen by UPDATE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            speed_r <= 4'd1;
        end else if (cmd_fire_s && (op_s == CMD_SET_SPEED)) begin
            speed_r <= cmd_data;
        end else begin
            speed_r <= speed_r;
        end
    end

    // Cel counter, cel toggle, rainbow phase and the update_done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cel_cnt_r <= '0;
            cel_r     <= 1'b0;
            phase_r   <= 3'd0;
            done_r    <= 1'b0;
        end else if (upd_s) begin
            cel_cnt_r <= cel_cnt_r + {{(CEL_BITS-1){1'b0}}, 1'b1};
            cel_r     <= (cel_cnt_r == CEL_LAST) ? ~cel_r : cel_r;
            phase_r   <= phase_r + 3'd1;
            done_r    <= 1'b1;
        end else begin
            cel_cnt_r <= cel_cnt_r;
            cel_r     <= cel_r;
            phase_r   <= phase_r;
            done_r    <= 1'b0;
        end
    end

    axis_bouncer #(.LIMIT(MAX_X), .POS_BITS(10), .INIT(INIT_LEFT)) u_axis_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (upd_s),
        .speed   (speed_r),
        .pos     (sprite_left),
        .dir     (dx_s)
    );

    axis_bouncer #(.LIMIT(MAX_Y), .POS_BITS(10), .INIT(INIT_TOP)) u_axis_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (upd_s),
        .speed   (speed_r),
        .pos     (sprite_top),
        .dir     (dy_s)
    );

    assign cmd_ready     = cmd_ready_r;
    assign cel_sel       = cel_r;
    assign rainbow_phase = phase_r;
    assign update_done   = done_r;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Bench for sprite_anim_sequencer: directed vector table, corner-case sequences, random vs. model.
module tb_sprite_anim_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [9:0] sprite_left;
    logic [9:0] sprite_top;
    logic       cel_sel;
    logic [2:0] rainbow_phase;
    logic       update_done;

    always #5 clk = ~clk;

    sprite_anim_sequencer #(.INIT_LEFT(128), .INIT_TOP(128), .FRAMES_PER_CEL(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .sprite_left   (sprite_left),
        .sprite_top    (sprite_top),
        .cel_sel       (cel_sel),
        .rainbow_phase (rainbow_phase),
        .update_done   (update_done)
    );

    localparam logic [1:0] OP_RUN = 2'd0, OP_PAUSE = 2'd1, OP_STEP = 2'd2, OP_SPD = 2'd3;
    localparam int M_PAUSED = 0, M_RUNNING = 1, M_STEP = 2;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model: sprite behaviour as plain integers; busy means an update is due at the next edge.
    int m_left, m_top, m_dx, m_dy, m_speed, m_cnt, m_cel, m_phase, m_mode;
    bit m_busy, m_done;

    function automatic void bounce(inout int pos, inout int dir, input int lim, input int spd);
        int n;
        if (spd != 0) begin
            n = dir ? pos + spd : pos - spd;
            if (n >= lim) begin pos = lim; dir = 0; end
            else if (n <= 0) begin pos = 0; dir = 1; end
            else pos = n;
        end
    endfunction

    function automatic void model_edge(bit rst, bit fs, bit cv, int op, int d);
        if (rst) begin
            m_left = 128; m_top = 128; m_dx = 1; m_dy = 1; m_speed = 1;
            m_cnt = 0; m_cel = 0; m_phase = 0; m_mode = M_PAUSED; m_busy = 0; m_done = 0;
        end else if (m_busy) begin
            bounce(m_left, m_dx, 640 - 272, m_speed);
            bounce(m_top, m_dy, 480 - 176, m_speed);
            m_cnt = m_cnt + 1;
            if (m_cnt == 16) begin m_cnt = 0; m_cel = 1 - m_cel; end
            m_phase = (m_phase + 1) % 8;
            m_busy = 0;
            m_done = 1;
        end else begin
            m_done = 0;
            if (cv && op == 3) m_speed = d;
            if (fs && m_mode != M_PAUSED) begin
                m_busy = 1;
                if (m_mode == M_STEP) m_mode = M_PAUSED;
                if (cv && op == 1) m_mode = M_PAUSED;
                else if (cv && op == 0) m_mode = M_RUNNING;
            end else if (cv) begin
                if (m_mode == M_PAUSED && op == 0) m_mode = M_RUNNING;
                else if (m_mode == M_PAUSED && op == 2) m_mode = M_STEP;
                else if (m_mode == M_RUNNING && op == 1) m_mode = M_PAUSED;
                else if (m_mode == M_STEP && op == 1) m_mode = M_PAUSED;
                else if (m_mode == M_STEP && op == 0) m_mode = M_RUNNING;
            end
        end
    endfunction

    task automatic step(input bit rst, input bit fs, input bit cv, input logic [1:0] op, input logic [3:0] d);
        rst_n = ~rst; frame_start = fs; cmd_valid = cv; cmd_op = op; cmd_data = d;
        @(posedge clk);
        model_edge(rst, fs, cv, int'(op), int'(d));
        #1;
        n_vec++;
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        cmp({tag, ".left"},  int'(sprite_left),   m_left);
        cmp({tag, ".top"},   int'(sprite_top),    m_top);
        cmp({tag, ".cel"},   int'(cel_sel),       m_cel);
        cmp({tag, ".phase"}, int'(rainbow_phase), m_phase);
        cmp({tag, ".done"},  int'(update_done),   int'(m_done));
        cmp({tag, ".ready"}, int'(cmd_ready),     int'(!m_busy));
    endtask

    task automatic frame(input string tag);
        step(1'b0, 1'b1, 1'b0, OP_RUN, 4'd0); cmp_model(tag);
        step(1'b0, 1'b0, 1'b0, OP_RUN, 4'd0); cmp_model(tag);
    endtask

    typedef struct {
        bit         rst, fs, cv;
        logic [1:0] op;
        logic [3:0] d;
        int         e_left, e_top, e_phase, e_done, e_ready;
    } vec_t;

    vec_t tbl[30];

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'd0;

        // Reset, RUN + 3 frames, STEP with a second pulse, PAUSE with frame_start, frame_start in UPDATE.
        tbl[0]  = '{1, 0, 0, OP_RUN,   4'd0, 128, 128, 0, 0, 1};
        tbl[1]  = '{0, 0, 1, OP_RUN,   4'd0, 128, 128, 0, 0, 1};
        tbl[2]  = '{0, 1, 0, OP_RUN,   4'd0, 128, 128, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, OP_RUN,   4'd0, 129, 129, 1, 1, 1};
        tbl[4]  = '{0, 1, 0, OP_RUN,   4'd0, 129, 129, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, OP_RUN,   4'd0, 130, 130, 2, 1, 1};
        tbl[6]  = '{0, 1, 0, OP_RUN,   4'd0, 130, 130, 2, 0, 0};
        tbl[7]  = '{0, 0, 0, OP_RUN,   4'd0, 131, 131, 3, 1, 1};
        tbl[8]  = '{0, 0, 0, OP_RUN,   4'd0, 131, 131, 3, 0, 1};
        tbl[9]  = '{0, 0, 1, OP_PAUSE, 4'd0, 131, 131, 3, 0, 1};
        tbl[10] = '{0, 0, 1, OP_STEP,  4'd0, 131, 131, 3, 0, 1};
        tbl[11] = '{0, 1, 0, OP_RUN,   4'd0, 131, 131, 3, 0, 0};
        tbl[12] = '{0, 0, 0, OP_RUN,   4'd0, 132, 132, 4, 1, 1};
        tbl[13] = '{0, 1, 0, OP_RUN,   4'd0, 132, 132, 4, 0, 1};
        tbl[14] = '{0, 0, 0, OP_RUN,   4'd0, 132, 132, 4, 0, 1};
        tbl[15] = '{0, 0, 1, OP_RUN,   4'd0, 132, 132, 4, 0, 1};
        tbl[16] = '{0, 1, 1, OP_PAUSE, 4'd0, 132, 132, 4, 0, 0};
        tbl[17] = '{0, 0, 0, OP_RUN,   4'd0, 133, 133, 5, 1, 1};
        tbl[18] = '{0, 1, 0, OP_RUN,   4'd0, 133, 133, 5, 0, 1};
        tbl[19] = '{0, 0, 0, OP_RUN,   4'd0, 133, 133, 5, 0, 1};
        tbl[20] = '{0, 1, 1, OP_RUN,   4'd0, 133, 133, 5, 0, 1};
        tbl[21] = '{0, 0, 0, OP_RUN,   4'd0, 133, 133, 5, 0, 1};
        tbl[22] = '{0, 1, 0, OP_RUN,   4'd0, 133, 133, 5, 0, 0};
        tbl[23] = '{0, 0, 0, OP_RUN,   4'd0, 134, 134, 6, 1, 1};
        tbl[24] = '{0, 1, 0, OP_RUN,   4'd0, 134, 134, 6, 0, 0};
        tbl[25] = '{0, 1, 0, OP_RUN,   4'd0, 135, 135, 7, 1, 1};
        tbl[26] = '{0, 0, 0, OP_RUN,   4'd0, 135, 135, 7, 0, 1};
        tbl[27] = '{0, 0, 1, OP_STEP,  4'd0, 135, 135, 7, 0, 1};
        tbl[28] = '{0, 1, 0, OP_RUN,   4'd0, 135, 135, 7, 0, 0};
        tbl[29] = '{0, 0, 0, OP_RUN,   4'd0, 136, 136, 0, 1, 1};

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].rst, tbl[i].fs, tbl[i].cv, tbl[i].op, tbl[i].d);
            cmp($sformatf("tbl%0d.left", i),  int'(sprite_left),   tbl[i].e_left);
            cmp($sformatf("tbl%0d.top", i),   int'(sprite_top),    tbl[i].e_top);
            cmp($sformatf("tbl%0d.phase", i), int'(rainbow_phase), tbl[i].e_phase);
            cmp($sformatf("tbl%0d.done", i),  int'(update_done),   tbl[i].e_done);
            cmp($sformatf("tbl%0d.ready", i), int'(cmd_ready),     tbl[i].e_ready);
            cmp($sformatf("tbl%0d.cel", i),   int'(cel_sel),       0);
        end

        // Speed 15 toward the right edge: 135 -> ... -> 360 -> 368 (clamped) -> 353.
        step(1'b1, 1'b0, 1'b0, OP_RUN, 4'd0); cmp_model("spd.rst");
        step(1'b0, 1'b0, 1'b1, OP_RUN, 4'd0); cmp_model("spd.run");
        for (int k = 0; k < 7; k++) frame("spd.slow");
        cmp("spd.left135", int'(sprite_left), 135);
        step(1'b0, 1'b1, 1'b1, OP_SPD, 4'd15); cmp_model("spd.set");
        step(1'b0, 1'b0, 1'b0, OP_RUN, 4'd0);  cmp_model("spd.set");
        cmp("spd.left150", int'(sprite_left), 150);
        for (int k = 0; k < 14; k++) frame("spd.fast");
        cmp("spd.left360", int'(sprite_left), 360);
        frame("spd.clamp");
        cmp("spd.left368", int'(sprite_left), 368);
        frame("spd.back");
        cmp("spd.left353", int'(sprite_left), 353);

        // 32 frames: cel toggles after the 16th and 32nd update, phase wraps every 8.
        step(1'b1, 1'b0, 1'b0, OP_RUN, 4'd0); cmp_model("cel.rst");
        step(1'b0, 1'b0, 1'b1, OP_RUN, 4'd0); cmp_model("cel.run");
        for (int k = 1; k <= 32; k++) begin
            frame("cel.frame");
            cmp($sformatf("cel.sel%0d", k),   int'(cel_sel),       (k / 16) % 2);
            cmp($sformatf("cel.phase%0d", k), int'(rainbow_phase), k % 8);
        end

        // Reset landing on the UPDATE cycle.
        step(1'b0, 1'b1, 1'b0, OP_RUN, 4'd0); cmp_model("rstupd.fs");
        cmp("rstupd.busy", int'(cmd_ready), 0);
        step(1'b1, 1'b0, 1'b0, OP_RUN, 4'd0); cmp_model("rstupd.rst");
        cmp("rstupd.left", int'(sprite_left), 128);
        cmp("rstupd.top", int'(sprite_top), 128);
        cmp("rstupd.phase", int'(rainbow_phase), 0);
        cmp("rstupd.done", int'(update_done), 0);
        step(1'b0, 1'b0, 1'b0, OP_RUN, 4'd0); cmp_model("rstupd.after");
        cmp("rstupd.nodone", int'(update_done), 0);
        frame("rstupd.paused");
        cmp("rstupd.still", int'(sprite_left), 128);

        // Random commands and frame pulses against the model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            cmp_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
